// File: rtl/blitter_wr_arbiter_if.sv
// Blitter write-arbiter bus bundle.
//   Engine side : req_valid/req_ready handshake plus packed address/byte_en/data
//                 (engine i at [26*i +: 26], [4*i +: 4], [32*i +: 32]).
//   FIFO side   : fifo_wr_address/byte_en/data/valid out, fifo_wr_full in.
//   Status      : grant_id (engine currently granted), busy (arbiter in GRANT).
// Modports: slave = the arbiter, master = the environment (engines + FIFO).
interface blitter_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*26-1:0] req_address;
  logic [NUM_REQ*4-1:0]  req_byte_en;
  logic [NUM_REQ*32-1:0] req_data;
  logic [25:0]           fifo_wr_address;
  logic [3:0]            fifo_wr_byte_en;
  logic [31:0]           fifo_wr_data;
  logic                  fifo_wr_valid;
  logic                  fifo_wr_full;
  logic [2:0]            grant_id;
  logic                  busy;

  modport slave (
    input  req_valid, req_address, req_byte_en, req_data, fifo_wr_full,
    output req_ready, fifo_wr_address, fifo_wr_byte_en, fifo_wr_data,
           fifo_wr_valid, grant_id, busy
  );

  modport master (
    output req_valid, req_address, req_byte_en, req_data, fifo_wr_full,
    input  req_ready, fifo_wr_address, fifo_wr_byte_en, fifo_wr_data,
           fifo_wr_valid, grant_id, busy
  );
endinterface

// File: rtl/blitter_wr_arbiter.sv
// Round-robin arbiter sharing the blitter FIFO write port among NUM_REQ engines.
// One engine is granted at a time for up to MAX_BURST beats; fifo_wr_full stalls
// the granted engine without releasing it. Accepted beats are registered onto the
// FIFO write interface with one cycle of latency.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high reset
//   bus    - blitter_wr_arbiter_if.slave: engine handshake/payload, FIFO write
//            port, grant_id and busy status
module blitter_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  blitter_wr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [2:0]   last_grant_q, last_grant_d;
  logic [2:0]   grant_id_q, grant_id_d;
  logic [3:0]   beat_cnt_q, beat_cnt_d;
  logic         wr_valid_q, wr_valid_d;
  logic [25:0]  wr_address_q, wr_address_d;
  logic [3:0]   wr_byte_en_q, wr_byte_en_d;
  logic [31:0]  wr_data_q, wr_data_d;

  logic               sel_valid;
  logic [25:0]        sel_address;
  logic [3:0]         sel_byte_en;
  logic [31:0]        sel_data;
  logic               found;
  logic [2:0]         pick;
  logic [3:0]         cand;
  logic [NUM_REQ-1:0] ready;
  logic               beat;

  // Mux the granted engine's request; a compare loop avoids a variable index
  // wider than the request vector.
  always_comb begin
    sel_valid   = 1'b0;
    sel_address = '0;
    sel_byte_en = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid   = bus.req_valid[i];
        sel_address = bus.req_address[26*i +: 26];
        sel_byte_en = bus.req_byte_en[4*i +: 4];
        sel_data    = bus.req_data[32*i +: 32];
      end
    end
  end

  // Round-robin search starting at last_grant+1; the released engine is checked
  // last, so it has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 4'(last_grant_q) + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && cand == 4'(i) && bus.req_valid[i]) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    wr_valid_d   = 1'b0;
    wr_address_d = wr_address_q;
    wr_byte_en_d = wr_byte_en_q;
    wr_data_d    = wr_data_q;
    ready        = '0;
    beat         = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          grant_id_d = pick;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == 3'(i)) ready[i] = !bus.fifo_wr_full;
        end
        beat = sel_valid && !bus.fifo_wr_full;
        if (beat) begin
          wr_valid_d   = 1'b1;
          wr_address_d = sel_address;
          wr_byte_en_d = sel_byte_en;
          wr_data_d    = sel_data;
          beat_cnt_d   = beat_cnt_q + 4'd1;
          if (beat_cnt_q == 4'(MAX_BURST - 1)) begin
            state_d      = IDLE;
            last_grant_d = grant_id_q;
            beat_cnt_d   = '0;
          end
        end else if (!sel_valid) begin
          // Engine went idle: release. A stall on fifo_wr_full alone keeps the grant.
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_address_q <= '0;
      wr_byte_en_q <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_valid_q   <= wr_valid_d;
      wr_address_q <= wr_address_d;
      wr_byte_en_q <= wr_byte_en_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.req_ready       = ready;
  assign bus.fifo_wr_valid   = wr_valid_q;
  assign bus.fifo_wr_address = wr_address_q;
  assign bus.fifo_wr_byte_en = wr_byte_en_q;
  assign bus.fifo_wr_data    = wr_data_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.busy            = (state_q == GRANT);

endmodule
